pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Lock supervisor and reset sequencer for the PLL wrappers. It consumes the PLL `locked` output and drives the PLL `rst` input: it pulses the PLL reset, waits for lock, and qualifies lock stability. Only then does it release the synchronous system reset to downstream logic. On loss of lock, lock timeout, or a software request, it re-arms the PLL.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on the asynchronous `locked` input (minimum 2).
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per reset pulse (minimum 1).
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum cycles waiting for lock before the PLL is re-pulsed.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release.

Ports:
- `refclk`  in  1: free-running reference clock, the only clock in the block.
- `rst`  in  1: reset, synchronous and active-high.
- `locked`  in  1: PLL lock indicator; asynchronous to `refclk`.
- `force_relock`  in  1: single-cycle request to re-run the full sequence; ignored outside RUN.
- `pll_rst`  out  1: reset to the PLL, active-high.
- `sys_rst`  out  1: synchronous system reset to downstream logic, active-high.
- `ready`  out  1: high only in RUN; equals `~sys_rst`.
- `relock_cnt`  out  8: count of re-arm events since `rst`; saturates at 255.

## Operation
- `locked` passes through a `SYNC_STAGES` synchronizer; its output is `locked_s`. The FSM uses only `locked_s`.
- All outputs are registered. Reset values:
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `relock_cnt`=0.
  - State is RESET_PLL, counters are 0, synchronizer is cleared to 0.
- There is one shared down-counter `cnt`, sized `$clog2` of the largest parameter plus 1.
- **RESET_PLL:** `pll_rst`=1 and `sys_rst`=1. Stay for exactly `PLL_RST_CYCLES` cycles, then go to WAIT_LOCK and load `cnt` with `LOCK_TIMEOUT_CYCLES`.
- **WAIT_LOCK:** `pll_rst`=0 and `sys_rst`=1.
  - If `locked_s`=1, go to STABLE and load `cnt` with `LOCK_STABLE_CYCLES-1`.
  - Otherwise, when `cnt` reaches 0, go to RESET_PLL and increment `relock_cnt`.
- **STABLE:** `sys_rst`=1.
  - If `locked_s`=0, go back to WAIT_LOCK and reload the timeout. `relock_cnt` does not change.
  - When `cnt` reaches 0 with `locked_s`=1, go to RUN.
- **RUN:** `sys_rst`=0 and `ready`=1.
  - A loss-of-lock event or `force_relock`=1 sends the FSM to RESET_PLL and increments `relock_cnt`.
  - If both occur in the same cycle, the result is a single transition and a single increment.
- `relock_cnt` holds at 255 and does not wrap.
- `rst` has priority over every state and event. Asserting it mid-sequence restores all reset values on the next edge.

## Timing
- Synchronizer latency is `SYNC_STAGES` cycles.
- `ready` rises and `sys_rst` falls on the edge exactly `SYNC_STAGES + LOCK_STABLE_CYCLES` cycles after the first edge that samples `locked`=1, provided `locked` stays high.
- Loss of lock in RUN (no filter): `sys_rst`=1 and `pll_rst`=1 on the edge `SYNC_STAGES + 1` cycles after `locked` falls.
- `force_relock` in RUN: `sys_rst`=1 and `pll_rst`=1 on the next edge.
- `pll_rst` high time is exactly `PLL_RST_CYCLES` cycles per pulse.
- After `rst` deasserts, the first pulse is `PLL_RST_CYCLES` cycles long, counted from the first edge with `rst`=0.
- The lock timeout fires on the edge `LOCK_TIMEOUT_CYCLES` cycles after WAIT_LOCK is entered.

## Configuration
- Macro: `PLL_SUP_GLITCH_FILTER_EN`.
- **Defined:** in RUN, a loss-of-lock event requires `locked_s`=0 for 4 consecutive cycles.
  - Shorter drops are ignored and do not change `relock_cnt`.
  - Total loss-to-`pll_rst` latency is `SYNC_STAGES + 4` cycles.
- **Undefined:** a single `locked_s`=0 cycle in RUN is a loss-of-lock event.
- The filter does not affect WAIT_LOCK or STABLE.

## Test plan
All scenarios use `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `LOCK_STABLE_CYCLES`=8.
- **Clean bring-up:** `rst` for 3 cycles, then `locked`=1 from cycle 10.
  - `pll_rst` is high for exactly 4 cycles.
  - `ready`=1 on the edge 10 cycles after `locked` is first sampled high.
  - `relock_cnt`=0.
- **Timeout:** hold `locked`=0.
  - `pll_rst` re-pulses for 4 cycles every 36 cycles.
  - `relock_cnt` reads 1, 2, 3, …, and saturates at 255 after 255 timeouts.
- **Unstable lock:** `locked` high for 5 cycles, low for 1, then high.
  - FSM returns to WAIT_LOCK with `relock_cnt` unchanged.
  - `ready` rises 10 cycles after the final rise.
- **Loss in RUN:** 1-cycle `locked` drop.
  - Without the macro: `sys_rst`=1 and `pll_rst`=1 three cycles later; `relock_cnt`=1.
  - With `PLL_SUP_GLITCH_FILTER_EN`: no reaction.
  - With the macro and a 4-cycle drop: reaction at 6 cycles.
- **`force_relock`:** one pulse in RUN coinciding with a lock drop.
  - Single RESET_PLL entry next cycle; `relock_cnt` increments by exactly 1.
  - `force_relock` asserted in WAIT_LOCK is ignored.
- **Reset mid-operation:** `rst` asserted in STABLE and in RUN.
  - Next edge: `pll_rst`=1, `sys_rst`=1, `ready`=0, `relock_cnt`=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for and qualifies lock, then releases sys_rst.
// Build option PLL_SUP_GLITCH_FILTER_EN: loss of lock in RUN must persist 4 synchronized cycles.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_cnt
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES
                                                                    : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [1:0] ST_RESET_PLL = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABLE    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   loss_evt;
    logic                   relock_evt;

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync[SYNC_STAGES-1];

`ifdef PLL_SUP_GLITCH_FILTER_EN
    logic [1:0] low_run;

    // Consecutive low samples seen while in RUN; the fourth one is a real loss.
    always_ff @(posedge refclk) begin
        if (rst || (state != ST_RUN) || locked_s) begin
            low_run <= '0;
        end else begin
            low_run <= low_run + 2'd1;
        end
    end

    assign loss_evt = ~locked_s && (low_run == 2'd3);
`else
    assign loss_evt = ~locked_s;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        relock_evt = 1'b0;
        case (state)
            // Counts up from 0 so the reset value of cnt already starts the first pulse.
            ST_RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = TIMEOUT_LOAD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = STABLE_LOAD;
                end else if (cnt <= CNT_ONE) begin
                    state_nxt  = ST_RESET_PLL;
                    cnt_nxt    = '0;
                    relock_evt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = TIMEOUT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                if (loss_evt || force_relock) begin
                    state_nxt  = ST_RESET_PLL;
                    cnt_nxt    = '0;
                    relock_evt = 1'b1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state      <= ST_RESET_PLL;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pll_rst <= (state_nxt == ST_RESET_PLL);
            sys_rst <= (state_nxt != ST_RUN);
            ready   <= (state_nxt == ST_RUN);
            if (relock_evt && (relock_cnt != 8'hFF)) begin
                relock_cnt <= relock_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: vector table for bring-up plus hand sequences, checked through a queue.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] relock_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES        (2),
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .relock_cnt  (relock_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        string name;
        int    n;
        logic  r;
        logic  l;
        logic  f;
        logic  ep;
        logic  es;
        logic  er;
        int    erc;
    } vec_t;

    typedef struct {
        string      name;
        logic       ep;
        logic       es;
        logic       er;
        logic [7:0] erc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add_vec(input string name, input int n, input logic r, input logic l,
                           input logic f, input logic ep, input logic es, input logic er,
                           input int erc);
        vec_t v;
        v.name = name; v.n = n; v.r = r; v.l = l; v.f = f;
        v.ep = ep; v.es = es; v.er = er; v.erc = erc;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input string fld, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d, want %0d (t=%0t)", name, fld, act, exp, $time);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "pll_rst", {7'd0, pll_rst}, {7'd0, e.ep});
        cmp(e.name, "sys_rst", {7'd0, sys_rst}, {7'd0, e.es});
        cmp(e.name, "ready", {7'd0, ready}, {7'd0, e.er});
        cmp(e.name, "relock_cnt", relock_cnt, e.erc);
    endtask

    // Drive inputs, queue the expectation, advance n edges, then compare just after the edge.
    task automatic step(input string name, input int n, input logic r, input logic l,
                        input logic f, input logic ep, input logic es, input logic er,
                        input int erc);
        exp_t e;
        rst = r; locked = l; force_relock = f;
        e.name = name; e.ep = ep; e.es = es; e.er = er; e.erc = 8'(erc);
        sb.push_back(e);
        repeat (n) @(posedge refclk);
        #1;
        check_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        rst = 1'b1; locked = 1'b0; force_relock = 1'b0;

        // name, cycles, rst, locked, force, exp pll_rst, sys_rst, ready, relock_cnt
        add_vec("reset",       3, 1, 0, 0, 1, 1, 0, 0);
        add_vec("pulse_hi",    3, 0, 0, 0, 1, 1, 0, 0);
        add_vec("pulse_end",   1, 0, 0, 0, 0, 1, 0, 0);
        add_vec("wait_lock",   5, 0, 0, 0, 0, 1, 0, 0);
        add_vec("stable_mid",  9, 0, 1, 0, 0, 1, 0, 0);
        add_vec("stable_last", 1, 0, 1, 0, 0, 1, 0, 0);
        add_vec("ready_rise",  1, 0, 1, 0, 0, 0, 1, 0);
        add_vec("run_hold",    5, 0, 1, 0, 0, 0, 1, 0);
        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].n, vecs[i].r, vecs[i].l, vecs[i].f,
                 vecs[i].ep, vecs[i].es, vecs[i].er, vecs[i].erc);
        end

        // Loss of lock while running.
`ifdef PLL_SUP_GLITCH_FILTER_EN
        step("glitch_drop",  1, 0, 0, 0, 0, 0, 1, 0);
        step("glitch_ign",   4, 0, 1, 0, 0, 0, 1, 0);
        step("loss4_drop",   4, 0, 0, 0, 0, 0, 1, 0);
        step("loss4_f4",     1, 0, 1, 0, 0, 0, 1, 0);
        step("loss4_react",  1, 0, 1, 0, 1, 1, 0, 1);
`else
        step("loss_drop",    1, 0, 0, 0, 0, 0, 1, 0);
        step("loss_f1",      1, 0, 1, 0, 0, 0, 1, 0);
        step("loss_react",   1, 0, 1, 0, 1, 1, 0, 1);
`endif
        step("loss_pulse",   3, 0, 1, 0, 1, 1, 0, 1);
        step("loss_pend",    1, 0, 1, 0, 0, 1, 0, 1);
        step("loss_stab",    8, 0, 1, 0, 0, 1, 0, 1);
        step("loss_rerun",   1, 0, 1, 0, 0, 0, 1, 1);

        // force_relock together with a lock drop, then force in WAIT_LOCK, then timeouts.
        step("force_drop",   1, 0, 0, 1, 1, 1, 0, 2);
        step("force_pulse",  3, 0, 0, 0, 1, 1, 0, 2);
        step("force_pend",   1, 0, 0, 0, 0, 1, 0, 2);
        step("force_wait",   1, 0, 0, 1, 0, 1, 0, 2);
        step("to_before",   30, 0, 0, 0, 0, 1, 0, 2);
        step("to_fire",      1, 0, 0, 0, 1, 1, 0, 3);
        step("to_pulse",     3, 0, 0, 0, 1, 1, 0, 3);
        step("to_pend",      1, 0, 0, 0, 0, 1, 0, 3);
        step("to2_before",  31, 0, 0, 0, 0, 1, 0, 3);
        step("to2_fire",     1, 0, 0, 0, 1, 1, 0, 4);
        rc = 4;
        for (int k = 0; k < 256; k++) begin
            step("to_loop_wait", 35, 0, 0, 0, 0, 1, 0, rc);
            rc = (rc < 255) ? rc + 1 : 255;
            step("to_loop_fire",  1, 0, 0, 0, 1, 1, 0, rc);
        end

        // Reset while in STABLE with a saturated counter.
        step("stable_in",    5, 0, 1, 0, 0, 1, 0, 255);
        step("rst_stable",   1, 1, 1, 0, 1, 1, 0, 0);
        step("rb_pulse",     3, 0, 1, 0, 1, 1, 0, 0);
        step("rb_pend",      1, 0, 1, 0, 0, 1, 0, 0);
        step("rb_stab",      8, 0, 1, 0, 0, 1, 0, 0);
        step("rb_ready",     1, 0, 1, 0, 0, 0, 1, 0);
        step("run_force",    1, 0, 1, 1, 1, 1, 0, 1);
        step("rf_seq",      12, 0, 1, 0, 0, 1, 0, 1);
        step("rf_ready",     1, 0, 1, 0, 0, 0, 1, 1);
        step("rst_run",      1, 1, 1, 0, 1, 1, 0, 0);

        // Unstable lock: 5 high, 1 low, then high.
        step("un_pulse",     4, 0, 0, 0, 0, 1, 0, 0);
        step("un_hi5",       5, 0, 1, 0, 0, 1, 0, 0);
        step("un_lo1",       1, 0, 0, 0, 0, 1, 0, 0);
        step("un_back",      2, 0, 1, 0, 0, 1, 0, 0);
        step("un_stab",      8, 0, 1, 0, 0, 1, 0, 0);
        step("un_ready",     1, 0, 1, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
